// File: rtl/valid_move_engine.sv
// rtl/valid_move_engine.sv - shared multi-channel valid-move engine over one map read port (optional VMD_WRAP_EN: tunnel wrap)
module valid_move_engine #(
    parameter int MAP_W       = 80,
    parameter int MAP_H       = 45,
    parameter int NUM_CH      = 5,
    parameter int MEM_LATENCY = 2,
    localparam int XW = $clog2(MAP_W),
    localparam int YW = $clog2(MAP_H),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CW-1:0]    req_chan,
    input  logic [XW-1:0]    req_idx_x,
    input  logic [YW-1:0]    req_idx_y,
    output logic             mem_rd_en,
    output logic [YW-1:0]    mem_addr,
    input  logic [MAP_W-1:0] mem_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CW-1:0]    rsp_chan,
    output logic [3:0]       rsp_moves,
    output logic             rsp_err
);

`ifdef VMD_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [XW:0]  X_MAX   = (XW+1)'(MAP_W - 1);
    localparam logic [YW:0]  Y_MAX   = (YW+1)'(MAP_H - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(MAP_H - 1);
    localparam logic [XW-1:0] X_LAST = XW'(MAP_W - 1);
    // capture points counted from the first read strobe
    localparam logic [2:0]   CAP_A   = 3'(MEM_LATENCY);
    localparam logic [2:0]   CAP_S   = 3'(MEM_LATENCY + 1);
    localparam logic [2:0]   CAP_B   = 3'(MEM_LATENCY + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t           state, state_n;
    logic [2:0]       cnt;
    logic [CW-1:0]    chan_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [MAP_W-1:0] above_q, same_q, below_w;
    logic             accept, req_oor;
    logic [XW:0]      xp1, xm1;
    logic             r_in, l_in, mv_r, mv_l, mv_u, mv_d;
    logic [XW-1:0]    ridx, lidx;
    logic [3:0]       moves_n;

    // row above y: wraps to the last row or clamps to y at the top edge
    function automatic logic [YW-1:0] row_above(input logic [YW-1:0] y);
        logic [YW:0] ym1;
        ym1 = {1'b0, y} - 1'b1;
        if (ym1[YW]) return WRAP ? Y_LAST : y;
        return ym1[YW-1:0];
    endfunction

    // row below y: wraps to row 0 or clamps to y at the bottom edge
    function automatic logic [YW-1:0] row_below(input logic [YW-1:0] y);
        logic [YW:0] yp1;
        yp1 = {1'b0, y} + 1'b1;
        if (yp1 > Y_MAX) return WRAP ? '0 : y;
        return yp1[YW-1:0];
    endfunction

    assign accept  = (state == IDLE) && req_valid && req_ready;
    assign req_oor = ({1'b0, req_idx_x} > X_MAX) || ({1'b0, req_idx_y} > Y_MAX);

    // move mask from the captured rows; the below row is taken straight off the bus on its capture cycle
    always_comb begin
        xp1     = {1'b0, x_q} + 1'b1;
        xm1     = {1'b0, x_q} - 1'b1;
        r_in    = (xp1 <= X_MAX);
        l_in    = ~xm1[XW];
        ridx    = r_in ? xp1[XW-1:0] : '0;
        lidx    = l_in ? xm1[XW-1:0] : X_LAST;
        below_w = (!WRAP && ({1'b0, y_q} == Y_MAX)) ? '0 : mem_rdata;
        mv_r    = (r_in | WRAP) & same_q[ridx];
        mv_l    = (l_in | WRAP) & same_q[lidx];
        mv_u    = above_q[x_q];
        mv_d    = below_w[x_q];
        moves_n = {mv_l, mv_d, mv_u, mv_r};
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid && req_ready) state_n = req_oor ? RESP : ISSUE;
            ISSUE:   if (cnt == 3'd2) state_n = DRAIN;
            DRAIN:   if (cnt == CAP_B) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // datapath: request latch, read sequencing, row captures and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            chan_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            above_q   <= '0;
            same_q    <= '0;
            req_ready <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_chan  <= '0;
            rsp_moves <= '0;
            rsp_err   <= 1'b0;
        end else begin
            req_ready <= (state_n == IDLE);
            mem_rd_en <= (state_n == ISSUE);
            rsp_valid <= (state_n == RESP);
            mem_addr  <= '0;
            if (accept) begin
                chan_q <= req_chan;
                x_q    <= req_idx_x;
                y_q    <= req_idx_y;
                cnt    <= '0;
                if (!req_oor) mem_addr <= row_above(req_idx_y);
            end else if (state == ISSUE || state == DRAIN) begin
                cnt <= cnt + 3'd1;
            end
            if (state == ISSUE) begin
                if (cnt == 3'd0)      mem_addr <= y_q;
                else if (cnt == 3'd1) mem_addr <= row_below(y_q);
            end
            if (state == ISSUE || state == DRAIN) begin
                if (cnt == CAP_A) above_q <= (!WRAP && y_q == '0) ? '0 : mem_rdata;
                if (cnt == CAP_S) same_q  <= mem_rdata;
            end
            if (accept && req_oor) begin
                rsp_chan  <= req_chan;
                rsp_moves <= 4'b0000;
                rsp_err   <= 1'b1;
            end else if (state == DRAIN && cnt == CAP_B) begin
                rsp_chan  <= chan_q;
                rsp_moves <= moves_n;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_valid_move_engine.sv
// tb/tb_valid_move_engine.sv - scoreboard bench for valid_move_engine with a latency-2 map memory model
module tb_valid_move_engine;
    localparam int MAP_W = 80;
    localparam int MAP_H = 45;
    localparam int XW = 7;
    localparam int YW = 6;
    localparam int CW = 3;
`ifdef VMD_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic             clk, rst;
    logic             req_valid, req_ready;
    logic [CW-1:0]    req_chan;
    logic [XW-1:0]    req_idx_x;
    logic [YW-1:0]    req_idx_y;
    logic             mem_rd_en;
    logic [YW-1:0]    mem_addr;
    logic [MAP_W-1:0] mem_rdata;
    logic             rsp_valid, rsp_ready;
    logic [CW-1:0]    rsp_chan;
    logic [3:0]       rsp_moves;
    logic             rsp_err;

    valid_move_engine dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan),
        .req_idx_x(req_idx_x), .req_idx_y(req_idx_y),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_chan(rsp_chan),
        .rsp_moves(rsp_moves), .rsp_err(rsp_err)
    );

    typedef struct packed {
        logic [CW-1:0] chan;
        logic [3:0]    moves;
        logic          err;
    } rsp_t;

    logic [MAP_W-1:0] map [MAP_H];
    rsp_t             exp_q[$];
    logic [YW-1:0]    addr_q[$];
    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    int               n_acc = 0;
    int               t_acc = 0;
    logic             e1;
    logic [YW-1:0]    a1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [MAP_W-1:0] rnd_row();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[MAP_W-1:0];
    endfunction

    function automatic rsp_t model(input int c, input int x, input int y);
        rsp_t r;
        logic up, dn, lf, rt;
        r.chan = CW'(c);
        if (x >= MAP_W || y >= MAP_H) begin
            r.moves = 4'b0000;
            r.err   = 1'b1;
        end else begin
            rt = (x == MAP_W-1) ? (WRAP ? map[y][0] : 1'b0) : map[y][x+1];
            lf = (x == 0) ? (WRAP ? map[y][MAP_W-1] : 1'b0) : map[y][x-1];
            up = (y == 0) ? (WRAP ? map[MAP_H-1][x] : 1'b0) : map[y-1][x];
            dn = (y == MAP_H-1) ? (WRAP ? map[0][x] : 1'b0) : map[y+1][x];
            r.moves = {lf, dn, up, rt};
            r.err   = 1'b0;
        end
        return r;
    endfunction

    // map memory: row valid two cycles after the strobe, junk otherwise
    always @(posedge clk) begin
        e1 <= mem_rd_en;
        a1 <= mem_addr;
        if (e1 && int'(a1) < MAP_H) mem_rdata <= map[a1];
        else                        mem_rdata <= rnd_row();
    end

    // scoreboard: push on accept, pop and compare on response handshake, flush on reset
    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp", 32'({rsp_chan, rsp_moves, rsp_err}), 32'(e));
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(model(int'(req_chan), int'(req_idx_x), int'(req_idx_y)));
                n_acc++;
            end
            if (mem_rd_en) addr_q.push_back(mem_addr);
        end
    end

    task automatic send(input int c, input int x, input int y);
        bit ok = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_chan  = CW'(c);
        req_idx_x = XW'(x);
        req_idx_y = YW'(y);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                t_acc = cyc;
                ok = 1;
                break;
            end
        end
        if (!ok) check("req_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("rsp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        bit quiet;
        rsp_t snap;
        logic [YW-1:0] exp_addr [3];
        for (int r = 0; r < MAP_H; r++) map[r] = rnd_row();
        rst = 1'b1; req_valid = 1'b0; req_chan = '0; req_idx_x = '0; req_idx_y = '0; rsp_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 32'({req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_chan, rsp_moves, rsp_err}), 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rst_ready_first", 32'(req_ready), 0);
        @(negedge clk);
        check("rst_ready_after", 32'(req_ready), 1);

        // interior tile with latency and address sequence
        map[4][10] = 1'b1; map[5][9] = 1'b1; map[5][11] = 1'b0; map[6][10] = 1'b0;
        addr_q.delete();
        send(2, 10, 5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("lat_wait", 32'(rsp_valid), 0);
        end
        @(negedge clk);
        check("lat_valid", 32'(rsp_valid), 1);
        check("lat_cycles", 32'(cyc - t_acc), 6);
        check("interior_moves", 32'(rsp_moves), 32'(4'b1010));
        check("interior_chan", 32'(rsp_chan), 2);
        wait_idle();
        exp_addr[0] = 6'd4; exp_addr[1] = 6'd5; exp_addr[2] = 6'd6;
        check("interior_nrd", addr_q.size(), 3);
        for (int k = 0; k < 3; k++)
            check("interior_addr", (addr_q.size() > k) ? 32'(addr_q[k]) : 32'hff, 32'(exp_addr[k]));

        // right edge
        map[20][0] = 1'b1;
        send(1, 79, 20);
        wait_rsp();
        check("right_edge", 32'(rsp_moves[0]), 32'(WRAP));
        wait_idle();

        // top edge
        map[44][30] = 1'b1;
        addr_q.delete();
        send(3, 30, 0);
        wait_rsp();
        check("top_edge_up", 32'(rsp_moves[1]), 32'(WRAP));
        wait_idle();
        check("top_first_addr", (addr_q.size() > 0) ? 32'(addr_q[0]) : 32'hff, WRAP ? 44 : 0);

        // other edges and corners through the model
        send(4, 0, 44);  wait_idle();
        send(0, 79, 0);  wait_idle();
        send(1, 0, 0);   wait_idle();
        send(2, 79, 44); wait_idle();

        // out of range on each axis
        addr_q.delete();
        send(1, 80, 5);
        check("oor_x_t1", 32'({rsp_valid, rsp_err, rsp_moves}), 32'(6'b110000));
        wait_idle();
        send(3, 5, 45);
        check("oor_y_t1", 32'({rsp_valid, rsp_err, rsp_moves}), 32'(6'b110000));
        wait_idle();
        check("oor_no_read", addr_q.size(), 0);

        // back-pressure with a second request held throughout
        a0 = n_acc;
        rsp_ready = 1'b0;
        send(1, 12, 7);
        req_valid = 1'b1; req_chan = 3'd3; req_idx_x = 7'd40; req_idx_y = 6'd30;
        wait_rsp();
        snap = {rsp_chan, rsp_moves, rsp_err};
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_hold", 32'({rsp_valid, rsp_chan, rsp_moves, rsp_err, req_ready}), 32'({1'b1, snap, 1'b0}));
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_hs", 32'(req_ready), 0);
        @(negedge clk);
        check("bp_ready_next", 32'(req_ready), 1);
        @(posedge clk); #1; req_valid = 1'b0;
        wait_idle();
        check("bp_accept_once", n_acc - a0, 2);

        // reset in the middle of draining
        send(2, 15, 15);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rst_mid_t5", 32'({mem_rd_en, rsp_valid, req_ready}), 0);
        @(negedge clk);
        check("rst_mid_ready", 32'(req_ready), 1);
        quiet = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) quiet = 0;
        end
        check("rst_mid_no_rsp", 32'(quiet), 1);
        send(0, 10, 5);
        wait_rsp();
        check("post_rst_moves", 32'(rsp_moves), 32'(4'b1010));
        wait_idle();

        // random traffic with occasional map updates
        for (int n = 0; n < 24; n++) begin
            if (n % 6 == 0) map[$urandom_range(MAP_H-1)] = rnd_row();
            send($urandom_range(4), $urandom_range(81), $urandom_range(46));
            wait_idle();
        end

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/valid_move_engine.md
Name: valid_move_engine

Overview:
- Multi-channel, parametrised successor to the single-character valid-move detector.
- Pacman and all ghosts share one engine, which time-multiplexes a single read port of the map block memory.
- Per request: reads the rows above, at and below the character's tile, then returns the 4-bit one-hot-per-direction move mask {Left, Down, Up, Right} over a valid/ready handshake.
- Sits between the character controllers (pacman FSM, ghost AI) and the map blockmem.

Parameters:
- MAP_W, 80: map columns; bits per memory row.
- MAP_H, 45: map rows; memory depth.
- NUM_CH, 5: requesting channels (0 = pacman, 1..4 = ghosts).
- MEM_LATENCY, 2: fixed cycles from mem_rd_en to valid mem_rdata (1..4).
- Derived: XW = clog2(MAP_W), YW = clog2(MAP_H), CW = max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept a request.
- req_chan  in  CW  requesting channel id.
- req_idx_x  in  XW  tile column.
- req_idx_y  in  YW  tile row.
- mem_rd_en  out  1  map read strobe.
- mem_addr  out  YW  map row address.
- mem_rdata  in  MAP_W  map row; bit i = column i; 1 = food/open, 0 = wall.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_chan  out  CW  channel id echoed from the request.
- rsp_moves  out  4  {Left, Down, Up, Right}; 1 = move allowed.
- rsp_err  out  1  request coordinates were out of range.

Behaviour:
- Reset: only clk and rst are fixed; all outputs are registered. On rst, state = IDLE, req_ready = 0 in the rst cycle and 1 on the following cycle. mem_rd_en, mem_addr, rsp_valid, rsp_chan, rsp_moves and rsp_err are all 0.
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - req_ready = 1.
  - Accept on req_valid && req_ready in cycle T; latch chan, x and y.
  - If x >= MAP_W or y >= MAP_H: go to RESP with rsp_err = 1 and moves = 0000. rsp_valid is asserted at T+1 and no memory read is issued.
  - Otherwise go to ISSUE.
- ISSUE: three consecutive cycles T+1, T+2, T+3 with mem_rd_en = 1 and mem_addr = row(y-1), y, row(y+1) respectively. Then go to DRAIN.
- DRAIN:
  - Capture mem_rdata MEM_LATENCY cycles after each rd_en cycle into the above, same and below row registers.
  - A 3-bit latency counter, not handshaking, sequences the captures.
  - Leave DRAIN after the last capture.
- RESP:
  - rsp_valid rises at T+4+MEM_LATENCY (T+6 at default).
  - Moves are computed from the registered rows: Right = same[x+1], Left = same[x-1], Up = above[x], Down = below[x].
  - Holds rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready, returns to IDLE; req_ready = 1 on the next cycle, so the minimum request spacing is 7 cycles at default.
- req_ready = 0 in every state except IDLE. A req_valid arriving while busy is not consumed; the requester holds it.
- Index arithmetic is done in XW+1 / YW+1 bits, with explicit compare against MAP_W-1 / MAP_H-1. Never index mem_rdata with an out-of-range value.
- Edge handling is set by the optional feature below; the edges are x = 0, x = MAP_W-1, y = 0 and y = MAP_H-1.
- rst mid-operation (any state): return to IDLE and drop the response. mem_rd_en = 0 from the next cycle. Any mem_rdata still in flight is ignored; the latency counter is cleared.
- rsp_chan always equals the chan of the request that produced the response; only one request is in flight.

Optional Feature:
- Macro: VMD_WRAP_EN.
- Defined: tunnel wrap-around on both axes.
  - x = MAP_W-1 → Right reads same[0].
  - x = 0 → Left reads same[MAP_W-1].
  - y = 0 → above row address = MAP_H-1.
  - y = MAP_H-1 → below row address = 0.
- Undefined: edges are hard walls.
  - Right = 0 at x = MAP_W-1; Left = 0 at x = 0; Up = 0 at y = 0; Down = 0 at y = MAP_H-1.
  - Three reads are still issued; the out-of-map row address is clamped to y, and its result is forced to 0.
  - Latency is identical in both builds.

Test Plan:
- Interior tile: chan=2, x=10, y=5; row4[10]=1, row5[9]=1, row5[11]=0, row6[10]=0 → rsp_moves=1010, rsp_chan=2, rsp_valid at T+6, mem_addr sequence 4, 5, 6.
- Right edge: x=79, y=20, row20[0]=1. With VMD_WRAP_EN → Right=1. Without → Right=0.
- Top edge: y=0, x=30, row44[30]=1. With VMD_WRAP_EN → first mem_addr=44 and Up=1. Without → first mem_addr=0 and Up=0.
- Back-pressure: rsp_ready held low for 5 cycles → rsp_* stable, req_ready=0. Then rsp_ready=1 → req_ready=1 on the next cycle. A second request held throughout is accepted exactly once.
- Out-of-range: x=80 or y=45 → rsp_err=1, rsp_moves=0000 at T+1, no mem_rd_en pulse.
- Reset mid-DRAIN: assert rst at T+4 → rsp_valid stays 0, mem_rd_en=0 from T+5, req_ready=1 after rst is released. A fresh request then returns correct moves with no stale data.
